// File: rtl/ram_sp_clr.sv
// Parametrised single-port synchronous RAM with a hardware clear sequencer.
// After reset, or on a clr request in IDLE, the sequencer zeroes the array one
// word per cycle; accesses made while it owns the array are dropped and flagged.
module ram_sp_clr #(
    parameter int DW         = 4,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int WRITE_MODE = 0   // 0 write-through, 1 read-first, 2 no-change
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          csn,
    input  logic          rwn,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          clr,
    output logic [DW-1:0] data_out,
    output logic          valid,
    output logic          busy,
    output logic          drop
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_IDLE  = 1'b1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;

    logic          in_range;
    logic [DW-1:0] rd_word;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Out-of-range addresses never touch the array: reads see zero, writes vanish.
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign rd_word  = in_range ? mem[addr] : '0;

    // Next-state, output and array-write decode for the CLEAR/IDLE sequencer.
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        drop_d     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = data_in;

        if (state_q == ST_CLEAR) begin
            // Sequencer owns the array; any access is dropped, clr is ignored.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            drop_d    = !csn;
            if (clr_ptr_q == LAST_PTR) begin
                state_d   = ST_IDLE;
                clr_ptr_d = '0;
            end else begin
                clr_ptr_d = clr_ptr_q + 1'b1;
            end
        end else if (clr) begin
            // Clear request wins over an access in the same cycle.
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
            drop_d    = !csn;
        end else if (!csn) begin
            if (rwn) begin
                data_out_d = rd_word;
                valid_d    = 1'b1;
            end else begin
                mem_we = in_range;
                if (WRITE_MODE == 0) begin
                    data_out_d = data_in;
                    valid_d    = 1'b1;
                end else if (WRITE_MODE == 1) begin
                    data_out_d = rd_word;
                    valid_d    = 1'b1;
                end
            end
        end
    end

    // Single array write port, shared by the sequencer and CPU writes.
    // NOTE: the array has no reset; zeroing it is the clear sequencer's job.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control and output registers with synchronous reset into a fresh sweep.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign drop     = drop_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: four instances (write-through, read-first, no-change,
// and a 12-word array) share one stimulus stream and are compared every cycle
// against a word-level behavioural model of the RAM and its clear sweep.
module tb_ram_sp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, csn, rwn, clr;
    logic [3:0] addr, din;

    logic [3:0] dout [4];
    logic       vld  [4];
    logic       bsy  [4];
    logic       drp  [4];

    ram_sp_clr #(.DW(4), .DEPTH(16), .AW(4), .WRITE_MODE(0)) u_wt (
        .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din), .clr(clr),
        .data_out(dout[0]), .valid(vld[0]), .busy(bsy[0]), .drop(drp[0]));
    ram_sp_clr #(.DW(4), .DEPTH(16), .AW(4), .WRITE_MODE(1)) u_rf (
        .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din), .clr(clr),
        .data_out(dout[1]), .valid(vld[1]), .busy(bsy[1]), .drop(drp[1]));
    ram_sp_clr #(.DW(4), .DEPTH(16), .AW(4), .WRITE_MODE(2)) u_nc (
        .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din), .clr(clr),
        .data_out(dout[2]), .valid(vld[2]), .busy(bsy[2]), .drop(drp[2]));
    ram_sp_clr #(.DW(4), .DEPTH(12), .AW(4), .WRITE_MODE(0)) u_d12 (
        .clk(clk), .rst(rst), .csn(csn), .rwn(rwn), .addr(addr), .data_in(din), .clr(clr),
        .data_out(dout[3]), .valid(vld[3]), .busy(bsy[3]), .drop(drp[3]));

    // Reference model: per instance, the memory contents and how many cycles of
    // clear sweep remain. The array is invisible while busy, so the model simply
    // zeroes all of it when the sweep finishes.
    int         dep  [4] = '{16, 16, 16, 12};
    int         mode [4] = '{0, 1, 2, 0};
    logic [3:0] mm   [4][16];
    int         busy_left [4];
    logic [3:0] e_do  [4];
    logic       e_vld [4];
    logic       e_drp [4];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input int idx, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] got=%h want=%h at %0t", tag, idx, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                busy_left[i] = dep[i];
                e_do[i]      = 4'h0;
                e_vld[i]     = 1'b0;
                e_drp[i]     = 1'b0;
            end else if (busy_left[i] > 0) begin
                e_vld[i] = 1'b0;
                e_drp[i] = !csn;
                busy_left[i]--;
                if (busy_left[i] == 0) begin
                    for (int j = 0; j < 16; j++) mm[i][j] = 4'h0;
                end
            end else if (clr) begin
                busy_left[i] = dep[i];
                e_vld[i]     = 1'b0;
                e_drp[i]     = !csn;
            end else if (csn) begin
                e_vld[i] = 1'b0;
                e_drp[i] = 1'b0;
            end else begin
                bit         inr;
                logic [3:0] old;
                inr      = int'(addr) < dep[i];
                old      = inr ? mm[i][addr] : 4'h0;
                e_drp[i] = 1'b0;
                if (rwn) begin
                    e_do[i]  = old;
                    e_vld[i] = 1'b1;
                end else begin
                    if (inr) mm[i][addr] = din;
                    case (mode[i])
                        0:       begin e_do[i] = din; e_vld[i] = 1'b1; end
                        1:       begin e_do[i] = old; e_vld[i] = 1'b1; end
                        default: e_vld[i] = 1'b0;
                    endcase
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input logic r, input logic c, input logic w,
                        input logic [3:0] a, input logic [3:0] d, input logic k);
        rst = r; csn = c; rwn = w; addr = a; din = d; clr = k;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("data_out", i, dout[i], e_do[i]);
            check("valid",    i, {3'b0, vld[i]}, {3'b0, e_vld[i]});
            check("busy",     i, {3'b0, bsy[i]}, {3'b0, busy_left[i] > 0});
            check("drop",     i, {3'b0, drp[i]}, {3'b0, e_drp[i]});
            check("valid_and_drop", i, {3'b0, vld[i] & drp[i]}, 4'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 1'b1, a, 4'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        step(1'b0, 1'b0, 1'b0, a, d, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 16; j++) mm[i][j] = 4'h0;
            busy_left[i] = 0;
        end

        // Reset, then read every address while busy (dropped) and after (zeros).
        step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        for (int a = 0; a < 16; a++) rd(4'(a));
        for (int a = 0; a < 16; a++) rd(4'(a));

        // Write then read the same address.
        wr(4'h3, 4'hA);
        rd(4'h3);

        // Read-first: old word comes back on the write.
        wr(4'h5, 4'h7);
        wr(4'h5, 4'h2);
        rd(4'h5);

        // No-change: data_out keeps the previous read value on a write.
        rd(4'h3);
        wr(4'h0, 4'hF);
        idle(1);

        // Fill with 9, clear with a colliding write, re-request clr mid-sweep.
        for (int a = 0; a < 16; a++) wr(4'(a), 4'h9);
        rd(4'h7);
        step(1'b0, 1'b0, 1'b0, 4'h4, 4'h1, 1'b1);
        for (int j = 0; j < 16; j++) step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, (j < 10) && (j % 2 == 0));
        for (int a = 0; a < 16; a++) rd(4'(a));

        // Out-of-range write/read around the 12-word instance's boundary.
        wr(4'h1, 4'h5);
        wr(4'hD, 4'h3);
        rd(4'hD);
        rd(4'h1);
        rd(4'hB);
        rd(4'hC);

        // Reset in the middle of a sweep restarts it.
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
        idle(6);
        step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        for (int j = 0; j < 14; j++) rd(4'(j));
        for (int a = 0; a < 16; a++) rd(4'(a));

        // Randomised traffic with occasional clears and resets.
        for (int j = 0; j < 400; j++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 1'($urandom),
                 4'($urandom),
                 4'($urandom),
                 $urandom_range(0, 49) == 0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
